// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control path.
// Holds the sequencer state encoding, the instruction classes the sequencer
// cares about, the opcode field position and a classifier helper used by
// the sequencer to pick its path through DECODE / EXEC / MEM / WB.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALTED
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_HALT
    } instr_class_t;

    localparam logic [3:0]  OP_LOAD    = 4'b0100;
    localparam logic [3:0]  OP_STORE   = 4'b0110;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam int          OPC_HI     = 16;
    localparam int          OPC_LO     = 13;

    // HALT is tested first: its opcode field is all ones, so it can never
    // alias LOAD or STORE, but checking it first keeps the intent obvious.
    function automatic instr_class_t classify(input logic [31:0] instr);
        if (instr == HALT_INSTR) begin
            return CLS_HALT;
        end else if (instr[OPC_HI:OPC_LO] == OP_LOAD) begin
            return CLS_LOAD;
        end else if (instr[OPC_HI:OPC_LO] == OP_STORE) begin
            return CLS_STORE;
        end else begin
            return CLS_ALU;
        end
    endfunction

endpackage

// File: rtl/multicycle_sequencer_ack_timeout.sv
// Ack wait watchdog for the sequencer's bus phases.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   clear      - restart the count (pulsed when a wait phase is entered)
//   waiting    - a request is outstanding this cycle
//   ack        - the matching acknowledge for the outstanding request
//   expired    - this cycle is the TIMEOUT-th unacknowledged wait cycle
module ack_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    input  logic ack,
    output logic expired
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (waiting && !ack) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Flags the cycle in which the count would reach TIMEOUT; an ack in
    // that same cycle masks it, so a last-moment ack still wins.
    assign expired = waiting && !ack && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 32-bit CPU. Fetches into the IR,
// steps the datapath through DECODE / EXEC / MEM / WB, and fires the
// register-file and data-memory write strobes once per instruction.
// Ports:
//   clk, reset             - system clock, synchronous active-high reset
//   run                    - keep sequencing instructions while high
//   imem_req/addr/ack/rdata - instruction fetch handshake
//   dmem_req/we/ack        - data memory handshake (we=1 for stores)
//   ir, pc                 - instruction register and program counter
//   rf_we                  - one-cycle register-file write pulse in WB
//   busy, halted           - status; busy is low only in IDLE and HALTED
//   bus_err                - sticky, set when an ack times out
//   instr_count            - retired-instruction counter (wraps)
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | imem request outstanding, latch IR and bump PC on ack
// DECODE | classify IR; HALT instruction stops here
// EXEC   | datapath execute cycle
// MEM    | dmem request outstanding (load or store)
// WB     | register-file write, retire
// HALTED | absorbing; only reset leaves
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int            PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int            TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [31:0]     ir,
    output logic [PC_W-1:0] pc,
    output logic            rf_we,
    output logic            busy,
    output logic            halted,
    output logic            bus_err,
    output logic [15:0]     instr_count
);

    state_t       state;
    state_t       state_next;
    instr_class_t cls;
    logic         fetch_done;
    logic         retire;
    logic         err_set;
    logic         waiting;
    logic         wait_ack;
    logic         wait_clear;
    logic         expired;

    assign cls = classify(ir);

    assign waiting  = (state == FETCH) || (state == MEM);
    assign wait_ack = (state == FETCH) ? imem_ack : dmem_ack;
    // Restart the watchdog whenever a bus phase is entered from elsewhere.
    assign wait_clear = (state_next != state) &&
                        ((state_next == FETCH) || (state_next == MEM));

    ack_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .waiting (waiting),
        .ack     (wait_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            instr_count <= '0;
            bus_err     <= 1'b0;
        end else begin
            state <= state_next;
            if (fetch_done) begin
                ir <= imem_rdata;
                pc <= pc + PC_W'(1);
            end
            if (retire) begin
                instr_count <= instr_count + 16'd1;
            end
            if (err_set) begin
                bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        fetch_done = 1'b0;
        retire     = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_done = 1'b1;
                    state_next = DECODE;
                end else if (expired) begin
                    err_set    = 1'b1;
                    state_next = HALTED;
                end
            end
            DECODE: begin
                state_next = (cls == CLS_HALT) ? HALTED : EXEC;
            end
            EXEC: begin
                state_next = ((cls == CLS_LOAD) || (cls == CLS_STORE)) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == CLS_STORE);
                if (dmem_ack) begin
                    if (cls == CLS_STORE) begin
                        retire     = 1'b1;
                        state_next = run ? FETCH : IDLE;
                    end else begin
                        state_next = WB;
                    end
                end else if (expired) begin
                    err_set    = 1'b1;
                    state_next = HALTED;
                end
            end
            WB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                state_next = run ? FETCH : IDLE;
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address is only meaningful while fetching; parked at zero otherwise.
    assign imem_addr = imem_req ? pc : '0;
    assign busy      = (state != IDLE) && (state != HALTED);
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. The main instance uses
// TIMEOUT=4 so the watchdog boundary is reachable; a second instance with
// RESET_PC=1023 covers PC wrap-around.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, run, imem_ack, dmem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, dmem_req, dmem_we, rf_we, busy, halted, bus_err;
    logic [9:0]  imem_addr, pc;
    logic [31:0] ir;
    logic [15:0] instr_count;

    logic        run_w, imem_ack_w, dmem_ack_w;
    logic [31:0] imem_rdata_w;
    logic        imem_req_w, dmem_req_w, dmem_we_w, rf_we_w, busy_w, halted_w, bus_err_w;
    logic [9:0]  imem_addr_w, pc_w;
    logic [31:0] ir_w;
    logic [15:0] instr_count_w;

    multicycle_sequencer #(.PC_W(10), .RESET_PC(10'd0), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir(ir), .pc(pc), .rf_we(rf_we), .busy(busy), .halted(halted),
        .bus_err(bus_err), .instr_count(instr_count)
    );

    multicycle_sequencer #(.PC_W(10), .RESET_PC(10'd1023), .TIMEOUT(255)) dut_w (
        .clk(clk), .reset(reset), .run(run_w),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w),
        .dmem_req(dmem_req_w), .dmem_we(dmem_we_w), .dmem_ack(dmem_ack_w),
        .ir(ir_w), .pc(pc_w), .rf_we(rf_we_w), .busy(busy_w), .halted(halted_w),
        .bus_err(bus_err_w), .instr_count(instr_count_w)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rom [0:15];
    int          imem_delay, dmem_delay, iw, dw;
    bit          imem_en, dmem_en;

    // One clock: respond to the main DUT's requests, then sample 1 ns after the edge.
    task automatic tick();
        logic ireq, dreq, iack, dack;
        imem_rdata = rom[imem_addr[3:0]];
        imem_ack   = imem_req && imem_en && (iw >= imem_delay);
        dmem_ack   = dmem_req && dmem_en && (dw >= dmem_delay);
        ireq = imem_req; dreq = dmem_req; iack = imem_ack; dack = dmem_ack;
        @(posedge clk);
        #1;
        iw = (ireq && !iack) ? iw + 1 : 0;
        dw = (dreq && !dack) ? dw + 1 : 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; run_w = 1'b0;
        imem_ack_w = 1'b0; dmem_ack_w = 1'b0; imem_rdata_w = '0;
        imem_en = 1'b1; dmem_en = 1'b1; imem_delay = 0; dmem_delay = 0;
        iw = 0; dw = 0;
        tick();
        tick();
        reset = 1'b0;
        iw = 0; dw = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem_req, dmem_req, dmem_we, rf_we, busy, halted, bus_err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {imem_req, dmem_req, dmem_we, rf_we, busy, halted, bus_err});
        end
        checks++;
        if ({pc, ir, instr_count, imem_addr} !== 68'd0) begin
            failures++;
            $display("FAIL reset_regs: pc=%0h ir=%0h cnt=%0h addr=%0h expected all 0", pc, ir, instr_count, imem_addr);
        end
        checks++;
        if (pc_w !== 10'd1023) begin
            failures++;
            $display("FAIL reset_pc_w: got %0d expected 1023", pc_w);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: busy=%b imem_req=%b expected 0 0", busy, imem_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] rf_hist, halt_hist;
        do_reset();
        rom[0] = 32'h0000_2000; rom[1] = 32'h0000_2000; rom[2] = 32'hFFFF_FFFF;
        rf_hist = '0; halt_hist = '0;
        run = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            rf_hist[k]   = rf_we;
            halt_hist[k] = halted;
        end
        checks++;
        if (rf_hist !== 12'h110) begin
            failures++;
            $display("FAIL b2b_rf_we_cycles: got %b expected %b", rf_hist, 12'h110);
        end
        checks++;
        if (halt_hist !== 12'h800) begin
            failures++;
            $display("FAIL b2b_halted_cycles: got %b expected %b", halt_hist, 12'h800);
        end
        checks++;
        if (instr_count !== 16'd2 || pc !== 10'd3 || ir !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL b2b_final: cnt=%0d pc=%0d ir=%0h expected 2 3 ffffffff", instr_count, pc, ir);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL halt_absorbing: halted=%b busy=%b bus_err=%b expected 1 0 0", halted, busy, bus_err);
        end
    endtask

    task automatic test_load();
        int req_n, we_n, rf_n, rf_at;
        do_reset();
        rom[0] = 32'h0000_8000; rom[1] = 32'hFFFF_FFFF;
        dmem_delay = 3;
        req_n = 0; we_n = 0; rf_n = 0; rf_at = 0;
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (dmem_req) req_n++;
            if (dmem_we) we_n++;
            if (rf_we) begin rf_n++; rf_at = k; end
        end
        tick();
        checks++;
        if (req_n !== 4 || we_n !== 0) begin
            failures++;
            $display("FAIL load_mem_phase: req_cycles=%0d we_cycles=%0d expected 4 0", req_n, we_n);
        end
        checks++;
        if (rf_n !== 1 || rf_at !== 8) begin
            failures++;
            $display("FAIL load_rf_we: pulses=%0d at=%0d expected 1 at 8", rf_n, rf_at);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'd1 || instr_count !== 16'd1) begin
            failures++;
            $display("FAIL load_latency: imem_req=%b addr=%0d cnt=%0d expected 1 1 1", imem_req, imem_addr, instr_count);
        end
    endtask

    task automatic test_store();
        int req_n, we_n, rf_n;
        logic [15:0] cnt5;
        do_reset();
        rom[0] = 32'h0000_C000; rom[1] = 32'hFFFF_FFFF;
        dmem_delay = 1;
        req_n = 0; we_n = 0; rf_n = 0; cnt5 = '0;
        run = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (dmem_req) req_n++;
            if (dmem_we) we_n++;
            if (rf_we) rf_n++;
            if (k == 5) cnt5 = instr_count;
        end
        tick();
        checks++;
        if (req_n !== 2 || we_n !== 2) begin
            failures++;
            $display("FAIL store_mem_phase: req_cycles=%0d we_cycles=%0d expected 2 2", req_n, we_n);
        end
        checks++;
        if (rf_n !== 0) begin
            failures++;
            $display("FAIL store_rf_we: got %0d pulses expected 0", rf_n);
        end
        checks++;
        if (cnt5 !== 16'd0 || instr_count !== 16'd1 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL store_retire: cnt_before=%0d cnt_after=%0d imem_req=%b expected 0 1 1", cnt5, instr_count, imem_req);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        run_w = 1'b1; imem_ack_w = 1'b1; imem_rdata_w = 32'h0000_2000;
        tick();
        checks++;
        if (imem_req_w !== 1'b1 || imem_addr_w !== 10'd1023) begin
            failures++;
            $display("FAIL wrap_fetch_addr: req=%b addr=%0d expected 1 1023", imem_req_w, imem_addr_w);
        end
        tick();
        checks++;
        if (pc_w !== 10'd0 || ir_w !== 32'h0000_2000) begin
            failures++;
            $display("FAIL wrap_pc: pc=%0d ir=%0h expected 0 2000", pc_w, ir_w);
        end
        run_w = 1'b0;
        tick();
        tick();
        checks++;
        if (rf_we_w !== 1'b1 || pc_w !== 10'd0) begin
            failures++;
            $display("FAIL wrap_wb: rf_we=%b pc=%0d expected 1 0", rf_we_w, pc_w);
        end
        tick();
        checks++;
        if (busy_w !== 1'b0 || instr_count_w !== 16'd1) begin
            failures++;
            $display("FAIL wrap_idle: busy=%b cnt=%0d expected 0 1", busy_w, instr_count_w);
        end
    endtask

    task automatic test_timeout();
        int rf_n;
        do_reset();
        rom[0] = 32'h0000_2000;
        imem_en = 1'b0;
        run = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if ({imem_req, bus_err, halted} !== 3'b100) begin
            failures++;
            $display("FAIL fetch_to_last_wait: req/err/halt=%b expected 100", {imem_req, bus_err, halted});
        end
        tick();
        checks++;
        if ({imem_req, bus_err, halted, busy} !== 4'b0110 || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL fetch_timeout: req/err/halt/busy=%b cnt=%0d expected 0110 0",
                     {imem_req, bus_err, halted, busy}, instr_count);
        end
        tick();
        checks++;
        if (bus_err !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL bus_err_sticky: err=%b req=%b expected 1 0", bus_err, imem_req);
        end

        do_reset();
        rom[0] = 32'h0000_2000;
        imem_delay = 3;
        run = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        checks++;
        if ({imem_req, bus_err, halted, busy} !== 4'b0001 || pc !== 10'd1 || ir !== 32'h0000_2000) begin
            failures++;
            $display("FAIL fetch_ack_last_cycle: req/err/halt/busy=%b pc=%0d ir=%0h expected 0001 1 2000",
                     {imem_req, bus_err, halted, busy}, pc, ir);
        end

        do_reset();
        rom[0] = 32'h0000_8000;
        dmem_en = 1'b0;
        rf_n = 0;
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rf_we) rf_n++;
        end
        checks++;
        if ({dmem_req, bus_err, halted} !== 3'b011 || rf_n !== 0 || instr_count !== 16'd0) begin
            failures++;
            $display("FAIL mem_timeout: req/err/halt=%b rf_pulses=%0d cnt=%0d expected 011 0 0",
                     {dmem_req, bus_err, halted}, rf_n, instr_count);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        rom[0] = 32'h0000_2000; rom[1] = 32'h0000_2000;
        run = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        checks++;
        if (rf_we !== 1'b1) begin
            failures++;
            $display("FAIL run_drop_wb: rf_we=%b expected 1", rf_we);
        end
        tick();
        checks++;
        if ({busy, imem_req, rf_we} !== 3'b000 || instr_count !== 16'd1) begin
            failures++;
            $display("FAIL run_drop_idle: busy/req/rf_we=%b cnt=%0d expected 000 1", {busy, imem_req, rf_we}, instr_count);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        rom[0] = 32'h0000_C000;
        dmem_en = 1'b0;
        run = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            failures++;
            $display("FAIL mid_mem_setup: req=%b we=%b expected 1 1", dmem_req, dmem_we);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({imem_req, dmem_req, dmem_we, rf_we, busy, halted, bus_err} !== 7'b0 ||
            {pc, ir, instr_count, imem_addr} !== 68'd0) begin
            failures++;
            $display("FAIL reset_mid_mem: flags=%b pc=%0h ir=%0h cnt=%0h expected all 0",
                     {imem_req, dmem_req, dmem_we, rf_we, busy, halted, bus_err}, pc, ir, instr_count);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        run_w = 1'b0; imem_ack_w = 1'b0; dmem_ack_w = 1'b0; imem_rdata_w = '0;
        for (int i = 0; i < 16; i++) rom[i] = 32'hFFFF_FFFF;
        test_reset();
        test_back_to_back();
        test_load();
        test_store();
        test_pc_wrap();
        test_timeout();
        test_run_drop();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 32-bit CPU. It fetches each instruction into an instruction register (IR) and steps the datapath through DECODE, EXEC, MEM and WB.
- It gates the register-file and data-memory write strobes so each fires exactly once per instruction.
- It sits between instruction memory, data memory and the combinational instruction decoder. The decoder reads `ir`; this block owns `pc` and the timing.

Parameters:
- PC_W, 10: program counter / instruction address width. The PC wraps modulo 2^PC_W.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT, 255: maximum cycles to wait for `imem_ack` or `dmem_ack` before raising `bus_err`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  enable. While high, the block sequences instructions continuously.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, equal to `pc` during FETCH.
- imem_ack  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable; 1 for a store.
- dmem_ack  in  1  data access complete; load data is valid this cycle.
- ir  out  32  instruction register, feeds the decoder.
- pc  out  PC_W  current PC, already incremented past `ir` once the fetch has completed.
- rf_we  out  1  one-cycle register-file write pulse.
- busy  out  1  high in any state other than IDLE and HALTED.
- halted  out  1  high in HALTED.
- bus_err  out  1  sticky flag: an ack timed out.
- instr_count  out  16  retired-instruction counter; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including reset mid-access):
  - state <= IDLE, pc <= RESET_PC, ir <= 0, instr_count <= 0, bus_err <= 0.
  - All request and strobe outputs are 0.
- Instruction classes, decoded from `ir`:
  - LOAD: ir[16:13] == 4'b0100.
  - STORE: ir[16:13] == 4'b0110.
  - HALT: ir == 32'hFFFF_FFFF.
  - ALU: everything else. ir[0] (register/immediate type) does not affect sequencing.
- State transitions:
  - IDLE: go to FETCH when `run` = 1; otherwise hold.
  - FETCH: `imem_req` = 1 and `imem_addr` = `pc`, both held stable until ack. On `imem_ack`: ir <= imem_rdata, pc <= pc + 1 (mod 2^PC_W), go to DECODE.
  - DECODE: one cycle. HALT goes to HALTED with no retire; all other classes go to EXEC.
  - EXEC: one cycle. LOAD or STORE goes to MEM; ALU goes to WB.
  - MEM: `dmem_req` = 1 and `dmem_we` = STORE, both held until ack. On `dmem_ack`: LOAD goes to WB; STORE retires (instr_count + 1) and goes to NEXT.
  - WB: `rf_we` = 1 for exactly this cycle; instr_count + 1; go to NEXT.
  - NEXT is not a state: it means FETCH if `run` = 1, otherwise IDLE.
  - HALTED: absorbing state; only reset leaves it.
- Latency, with ack asserted in the same cycle as req:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- Each added wait cycle on an ack adds 1 cycle of latency.
- Dropping `run` mid-instruction never aborts: the current instruction completes, then the FSM goes to IDLE.
- Timeout:
  - An 8-bit-or-wider wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When it reaches TIMEOUT: bus_err <= 1, request deasserted next cycle, go to HALTED, no retire, no write strobe.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins; no error is raised.
- An ack outside FETCH/MEM, or outside the matching state, is ignored.
- `rf_we` and `dmem_we` are never high outside WB and MEM respectively.
- `ir` is stable from the DECODE cycle through the end of the instruction.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - State enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED.
  - Opcode constants: OP_LOAD = 4'b0100, OP_STORE = 4'b0110.
  - HALT_INSTR = 32'hFFFF_FFFF.
  - Field slice positions: OPC_HI = 16, OPC_LO = 13.
- Sub-module `ack_timeout`:
  - Inputs: clk, reset, clear, waiting, ack.
  - Output: expired.
  - Counter width derived from TIMEOUT.

Test Plan:
- Reset then run = 1; IR words 32'h0000_2000 (ALU), 32'h0000_2000, 32'hFFFF_FFFF with zero-wait acks -> `rf_we` pulses on cycles 4 and 8, halted = 1 at cycle 11, instr_count = 2, pc = 3.
- LOAD 32'h0000_8000 with `dmem_ack` delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we = 0, one `rf_we` pulse after ack, total latency 8.
- STORE 32'h0000_C000 -> dmem_we = 1 for the whole MEM phase, `rf_we` never asserts, instr_count + 1 on ack.
- RESET_PC = 1023, PC_W = 10, ALU instruction -> after fetch pc = 0 (wrap); imem_addr = 1023 during the first FETCH.
- TIMEOUT = 4, `imem_ack` held low -> bus_err = 1 and halted = 1 after 4 wait cycles, imem_req = 0 afterwards; ack in the 4th cycle instead -> no error.
- `run` dropped during EXEC of an ALU op -> WB still pulses `rf_we`, then IDLE with busy = 0. Reset asserted mid-MEM -> next cycle all outputs = 0, pc = RESET_PC.
